transmit_beamformer: RTL and testbench
======================================

// Module: transmit_beamformer
// PURPOSE
//  Transmit-side counterpart of the receive beamformer. Periodically fires a burst of
//  TARGET_FREQ square waves on NUM_TRANSMITTERS ultrasonic elements. Each element is
//  delayed by a per-element sample count derived from sin_theta, which steers the
//  wavefront toward the commanded angle. Sits between the angle sequencer and the
//  transducer drivers. Its burst timing frames the receive window.
// PARAMETERS
//  PERIOD_DURATION  16777216   clocks per ping period (burst + listen)
//  BURST_DURATION   524288     clocks each element drives its burst
//  NUM_TRANSMITTERS 2          number of transmit elements
//  ELEMENT_SPACING  9          element pitch, mm
//  SPEED_OF_SOUND   343000     mm/s
//  TARGET_FREQ      40000      carrier frequency, Hz
//  CLK_FREQ         100000000  clk_in frequency, Hz
//  SIN_WIDTH        17         sin_theta width, unsigned Q1.(SIN_WIDTH-1); 65536 = 1.0
//  DELAY_WIDTH      16         per-element delay register width, clocks
// PORTS
//  clk_in          in   1                   system clock (single clock domain)
//  rst_in          in   1                   async active-high reset
//  enable_in       in   1                   run periodic pings while high
//  sin_theta       in   SIN_WIDTH           |sin| of steering angle
//  sign_bit        in   1                   1 = steer left, 0 = steer right
//  angle_valid_in  in   1                   strobe: capture sin_theta/sign_bit
//  tx_out          out  NUM_TRANSMITTERS    per-element drive, bit k = element k
//  burst_start_out out  1                   1-cycle pulse on the first cycle of each period
//  burst_active_out out 1                   high while any element is inside its burst window
//  busy_out        out  1                   high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, period counter c=0, shadow angle=0/0, delays=0.
//  Constants: DLY_PER_EL = ELEMENT_SPACING*CLK_FREQ/SPEED_OF_SOUND (=2623).
//   HALF_PER = CLK_FREQ/(2*TARGET_FREQ) (=1250).
//  Angle: angle_valid_in loads the shadow register on any cycle. The active angle is
//   copied from the shadow only in LATCH, so an update mid-period applies next period.
//  Delay, computed in LATCH with 32-bit math:
//   d_k = (DLY_PER_EL*m_k*sin_theta) >> (SIN_WIDTH-1).
//   m_k = NUM_TRANSMITTERS-1-k if sign_bit, else m_k = k.
//   Saturate d_k at 2^DELAY_WIDTH-1.
//  FSM:
//   IDLE  -> LATCH when enable_in=1.
//   LATCH (1 cycle) -> FIRE. c<=0, burst_start_out=1 for that first FIRE cycle.
//   FIRE  -> LISTEN when c == max_k(d_k)+BURST_DURATION.
//   LISTEN -> LATCH when c == PERIOD_DURATION-1 and enable_in=1.
//   LISTEN -> IDLE when c == PERIOD_DURATION-1 and enable_in=0.
//  enable_in deassert mid-period: the current burst and period complete, then the FSM
//   goes to IDLE. There is no truncated burst.
//  tx_out[k] is registered. It is high during FIRE cycles c in (d_k, d_k+BURST_DURATION]
//   where floor((c-d_k-1)/HALF_PER) is even, and low otherwise. Each element starts
//   high, and its phase is relative to that element's own start.
//  Implement the phase with a per-element down-counter, not a divider.
//  Constraint (elaboration $error): PERIOD_DURATION > BURST_DURATION + (N-1)*DLY_PER_EL.
//  Async reset mid-burst: tx_out drops to 0 immediately. Restart is via LATCH.
// CONFIGURATION
//  TX_BLANKING_EN defined: adds output rx_blank_out (1 bit, reset 0).
//   rx_blank_out is high from the first FIRE cycle until HALF_PER clocks after FIRE
//   exits. It gates the receive beamformer against direct-path ringing.
//  TX_BLANKING_EN undefined: the port is absent and the blanking logic is not built.
// STRUCTURE
//  Package tx_bf_pkg: DLY_PER_EL and HALF_PER localparams, fsm_state_t enum
//   (IDLE, LATCH, FIRE, LISTEN), and delay_calc() function shared with receive_beamformer.
//  Sub-module tx_element_driver (one per element via generate). It holds d_k, the
//   burst down-counter and the half-period toggle counter, and outputs tx_out[k].
// TESTING
//  sin_theta=0, enable=1 -> tx_out[0]/[1] rise on the same cycle; 1250 high, 1250 low.
//   Each element stays active for 524288 clocks.
//  sin_theta=65536, sign=0 -> tx_out[1] rises exactly 2623 clocks after tx_out[0].
//   Same input with sign=1 -> tx_out[0] lags tx_out[1] by 2623.
//  Change the angle mid-FIRE -> current burst timing unchanged; new delays apply after
//   the next burst_start_out.
//  Drop enable mid-burst -> burst completes, LISTEN runs to c=PERIOD_DURATION-1,
//   then IDLE with busy_out=0.
//  Assert rst_in mid-burst -> all outputs 0 the same cycle. After release, stays IDLE
//   until enable_in.
//  With TX_BLANKING_EN -> rx_blank_out is high from the first FIRE cycle through
//   FIRE-exit+1250 clocks.

Source files
------------

// File: rtl/tx_bf_pkg.sv
// Shared transmit/receive beamformer definitions: timing constants, FSM states
// and the steering delay calculation.
package tx_bf_pkg;

    localparam int DLY_PER_EL = 9 * 100000000 / 343000;
    localparam int HALF_PER   = 100000000 / (2 * 40000);

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        FIRE,
        LISTEN
    } fsm_state_t;

    // (dly_per_el * m * sin) >> shift, clamped to an unsigned dw-bit value
    function automatic logic [31:0] delay_calc(
        input logic [31:0] dly_per_el,
        input logic [31:0] m,
        input logic [31:0] sin_val,
        input int          shift,
        input int          dw
    );
        logic [31:0] prod;
        logic [31:0] lim;
        prod = (dly_per_el * m * sin_val) >> shift;
        lim  = (32'd1 << dw) - 32'd1;
        return (prod > lim) ? lim : prod;
    endfunction

endpackage

// File: rtl/transmit_beamformer_if.sv
// Control/drive bundle between the angle sequencer, the transmit beamformer and
// the transducer drivers. TX_BLANKING_EN adds the rx_blank_out gate.
interface transmit_beamformer_if #(
    parameter int NUM_TRANSMITTERS = 2,
    parameter int SIN_WIDTH        = 17
);
    logic                        enable_in;
    logic [SIN_WIDTH-1:0]        sin_theta;
    logic                        sign_bit;
    logic                        angle_valid_in;
    logic [NUM_TRANSMITTERS-1:0] tx_out;
    logic                        burst_start_out;
    logic                        burst_active_out;
    logic                        busy_out;

`ifdef TX_BLANKING_EN
    logic                        rx_blank_out;

    modport master (
        output enable_in, sin_theta, sign_bit, angle_valid_in,
        input  tx_out, burst_start_out, burst_active_out, busy_out, rx_blank_out
    );
    modport slave (
        input  enable_in, sin_theta, sign_bit, angle_valid_in,
        output tx_out, burst_start_out, burst_active_out, busy_out, rx_blank_out
    );
`else
    modport master (
        output enable_in, sin_theta, sign_bit, angle_valid_in,
        input  tx_out, burst_start_out, burst_active_out, busy_out
    );
    modport slave (
        input  enable_in, sin_theta, sign_bit, angle_valid_in,
        output tx_out, burst_start_out, burst_active_out, busy_out
    );
`endif

endinterface

// File: rtl/tx_element_driver.sv
// One transmit element: holds its steering delay, waits it out, then drives a
// square-wave burst that starts high, timed by a burst and a half-period counter.
module tx_element_driver #(
    parameter int BURST_DURATION = 524288,
    parameter int HALF_PER       = 1250,
    parameter int DELAY_WIDTH    = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   load,
    input  logic                   fire,
    input  logic [DELAY_WIDTH-1:0] delay_new,
    output logic [DELAY_WIDTH-1:0] delay,
    output logic                   tx,
    output logic                   active
);
    localparam int BW = $clog2(BURST_DURATION + 1);
    localparam int HW = $clog2(HALF_PER + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_DURATION - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PER - 1);

    logic [DELAY_WIDTH-1:0] wait_cnt;
    logic [BW-1:0]          burst_cnt;
    logic [HW-1:0]          half_cnt;
    logic                   armed;

    // load lands on the cycle before c=0, so wait_cnt hits zero on cycle c=d
    // and tx is high from c=d+1 onward
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            delay     <= '0;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            half_cnt  <= '0;
            armed     <= 1'b0;
            active    <= 1'b0;
            tx        <= 1'b0;
        end else if (load) begin
            delay    <= delay_new;
            wait_cnt <= delay_new;
            armed    <= 1'b1;
            active   <= 1'b0;
            tx       <= 1'b0;
        end else if (fire && armed) begin
            if (wait_cnt == '0) begin
                armed     <= 1'b0;
                active    <= 1'b1;
                tx        <= 1'b1;
                burst_cnt <= BURST_LAST;
                half_cnt  <= HALF_LAST;
            end else begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end else if (fire && active) begin
            if (burst_cnt == '0) begin
                active <= 1'b0;
                tx     <= 1'b0;
            end else begin
                burst_cnt <= burst_cnt - 1'b1;
                if (half_cnt == '0) begin
                    tx       <= ~tx;
                    half_cnt <= HALF_LAST;
                end else begin
                    half_cnt <= half_cnt - 1'b1;
                end
            end
        end else begin
            armed  <= 1'b0;
            active <= 1'b0;
            tx     <= 1'b0;
        end
    end

endmodule

// File: rtl/transmit_beamformer.sv
// Periodic steered-burst transmitter: IDLE/LATCH/FIRE/LISTEN sequencer plus one
// tx_element_driver per element. TX_BLANKING_EN adds the rx_blank_out window.
module transmit_beamformer
    import tx_bf_pkg::*;
#(
    parameter int PERIOD_DURATION  = 16777216,
    parameter int BURST_DURATION   = 524288,
    parameter int NUM_TRANSMITTERS = 2,
    parameter int ELEMENT_SPACING  = 9,
    parameter int SPEED_OF_SOUND   = 343000,
    parameter int TARGET_FREQ      = 40000,
    parameter int CLK_FREQ         = 100000000,
    parameter int SIN_WIDTH        = 17,
    parameter int DELAY_WIDTH      = 16
) (
    input logic                  clk_in,
    input logic                  rst_in,
    transmit_beamformer_if.slave bf
);
    localparam int DLY_CLKS  = ELEMENT_SPACING * CLK_FREQ / SPEED_OF_SOUND;
    localparam int HALF_CLKS = CLK_FREQ / (2 * TARGET_FREQ);
    localparam int CW        = $clog2(PERIOD_DURATION);
    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_DURATION - 1);

    if (PERIOD_DURATION <= BURST_DURATION + (NUM_TRANSMITTERS - 1) * DLY_CLKS) begin : g_cfg_check
        $error("PERIOD_DURATION must exceed BURST_DURATION plus the widest steering delay");
    end

    fsm_state_t state, state_nxt;
    logic [CW-1:0]          c;
    logic [31:0]            c32;
    logic [31:0]            fire_end;
    logic [SIN_WIDTH-1:0]   shadow_sin;
    logic                   shadow_sign;
    logic [DELAY_WIDTH-1:0] d_new [NUM_TRANSMITTERS];
    logic [DELAY_WIDTH-1:0] d_cur [NUM_TRANSMITTERS];
    logic [DELAY_WIDTH-1:0] max_d;
    logic [NUM_TRANSMITTERS-1:0] tx_bits;
    logic [NUM_TRANSMITTERS-1:0] act_bits;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shadow_sin  <= '0;
            shadow_sign <= 1'b0;
        end else if (bf.angle_valid_in) begin
            shadow_sin  <= bf.sin_theta;
            shadow_sign <= bf.sign_bit;
        end
    end

    // The shadow angle only reaches the elements through the LATCH load.
    always_comb begin
        for (int k = 0; k < NUM_TRANSMITTERS; k++) begin
            d_new[k] = DELAY_WIDTH'(delay_calc(32'(DLY_CLKS),
                                               shadow_sign ? 32'(NUM_TRANSMITTERS - 1 - k) : 32'(k),
                                               32'(shadow_sin), SIN_WIDTH - 1, DELAY_WIDTH));
        end
    end

    always_comb begin
        max_d = '0;
        for (int k = 0; k < NUM_TRANSMITTERS; k++) begin
            if (d_cur[k] > max_d) max_d = d_cur[k];
        end
    end

    assign c32      = 32'(c);
    assign fire_end = 32'(max_d) + 32'(BURST_DURATION);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            c     <= '0;
        end else begin
            state <= state_nxt;
            if (state == FIRE || state == LISTEN) c <= c + 1'b1;
            else                                  c <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bf.enable_in) state_nxt = LATCH;
            LATCH: state_nxt = FIRE;
            FIRE, LISTEN: begin
                if (c32 == PERIOD_LAST)                      state_nxt = bf.enable_in ? LATCH : IDLE;
                else if (state == FIRE && c32 == fire_end)   state_nxt = LISTEN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_TRANSMITTERS; k++) begin : g_el
        tx_element_driver #(
            .BURST_DURATION(BURST_DURATION),
            .HALF_PER      (HALF_CLKS),
            .DELAY_WIDTH   (DELAY_WIDTH)
        ) u_drv (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .load     (state == LATCH),
            .fire     (state == FIRE),
            .delay_new(d_new[k]),
            .delay    (d_cur[k]),
            .tx       (tx_bits[k]),
            .active   (act_bits[k])
        );
    end

    assign bf.tx_out           = tx_bits;
    assign bf.burst_start_out  = (state == FIRE) && (c == '0);
    assign bf.burst_active_out = |act_bits;
    assign bf.busy_out         = (state != IDLE);

`ifdef TX_BLANKING_EN
    localparam int TW = $clog2(HALF_CLKS + 1);
    logic [TW-1:0] tail;

    // Blanking covers all of FIRE and a further half carrier period of ring-down.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                                  tail <= '0;
        else if (state == FIRE && state_nxt != FIRE) tail <= TW'(HALF_CLKS);
        else if (tail != '0)                         tail <= tail - 1'b1;
    end

    assign bf.rx_blank_out = (state == FIRE) || (tail != '0);
`endif

endmodule

// File: tb/tb_transmit_beamformer.sv
// Scoreboard bench for transmit_beamformer (short period/burst, default carrier
// and element timing). Checks rx_blank_out too when TX_BLANKING_EN is defined.
`timescale 1ns/1ps
module tb_transmit_beamformer;
    localparam int PERIOD = 10000;
    localparam int BURST  = 5500;
    localparam int HALF   = 1250;
    localparam int PULSES = 3;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;

    transmit_beamformer_if #(.NUM_TRANSMITTERS(2), .SIN_WIDTH(17)) bf();

    transmit_beamformer #(
        .PERIOD_DURATION(PERIOD),
        .BURST_DURATION (BURST)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bf    (bf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d0;
        int d1;
        int gap;
    } ping_t;

    ping_t exp_q[$];
    int    busy_q[$];
`ifdef TX_BLANKING_EN
    int    blank_q[$];
`endif

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ping(input int d0, input int d1, input int gap);
        ping_t p;
        p.d0 = d0; p.d1 = d1; p.gap = gap;
        exp_q.push_back(p);
`ifdef TX_BLANKING_EN
        blank_q.push_back(((d0 > d1) ? d0 : d1) + BURST + HALF + 1);
`endif
    endtask

    // Monitor state
    int   start_cyc, gap, act_len, blank_len;
    bit   in_burst, have_prev;
    int   rise[2], last[2], hi[2], nrise[2];
    logic [1:0] ptx;
    logic pact, pbusy, pblank;

    task automatic score_ping();
        ping_t e;
        int mx, mn;
        check("ping_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            mx = (e.d0 > e.d1) ? e.d0 : e.d1;
            mn = (e.d0 < e.d1) ? e.d0 : e.d1;
            check("rise0", rise[0], e.d0 + 1);
            check("rise1", rise[1], e.d1 + 1);
            check("last_high0", last[0], e.d0 + BURST);
            check("last_high1", last[1], e.d1 + BURST);
            check("first_pulse0", hi[0], HALF);
            check("first_pulse1", hi[1], HALF);
            check("pulses0", nrise[0], PULSES);
            check("pulses1", nrise[1], PULSES);
            check("active_len", act_len, mx + BURST - mn);
            if (e.gap != 0) check("period_gap", gap, e.gap);
        end
    endtask

    task automatic score_busy(input int dur);
        check("busy_fall_expected", int'(busy_q.size() > 0), 1);
        if (busy_q.size() > 0) check("busy_len", dur, busy_q.pop_front());
    endtask

    initial begin
        in_burst = 0; have_prev = 0; ptx = '0; pact = 0; pbusy = 0; pblank = 0;
        start_cyc = 0; gap = 0; act_len = 0; blank_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_burst = 0; have_prev = 0; ptx = '0; pact = 0; pbusy = 0; pblank = 0;
            end else begin
                if (bf.burst_start_out) begin
                    gap       = have_prev ? cyc - start_cyc : 0;
                    have_prev = 1;
                    start_cyc = cyc;
                    in_burst  = 1;
                    act_len   = 0;
                    blank_len = 0;
                    for (int k = 0; k < 2; k++) begin
                        rise[k] = -1; last[k] = -1; hi[k] = -1; nrise[k] = 0;
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (bf.tx_out[k] && !ptx[k]) begin
                        nrise[k]++;
                        if (rise[k] < 0) rise[k] = cyc - start_cyc;
                    end
                    if (!bf.tx_out[k] && ptx[k] && hi[k] < 0) hi[k] = cyc - start_cyc - rise[k];
                    if (bf.tx_out[k]) last[k] = cyc - start_cyc;
                end
                if (bf.burst_active_out) act_len++;
                if (!bf.burst_active_out && pact && in_burst) begin
                    in_burst = 0;
                    score_ping();
                end
                if (!bf.busy_out && pbusy) score_busy(cyc - start_cyc);
`ifdef TX_BLANKING_EN
                if (bf.rx_blank_out) blank_len++;
                if (!bf.rx_blank_out && pblank) begin
                    check("blank_expected", int'(blank_q.size() > 0), 1);
                    if (blank_q.size() > 0) check("blank_len", blank_len, blank_q.pop_front());
                end
                pblank = bf.rx_blank_out;
`endif
                ptx   = bf.tx_out;
                pact  = bf.burst_active_out;
                pbusy = bf.busy_out;
            end
        end
    end

    task automatic set_angle(input int s, input logic sg);
        bf.sin_theta      = 17'(s);
        bf.sign_bit       = sg;
        bf.angle_valid_in = 1'b1;
        @(negedge clk);
        bf.angle_valid_in = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!bf.burst_start_out && n < 2 * PERIOD + 100) begin
            @(negedge clk);
            n++;
        end
        check("burst_start_seen", int'(bf.burst_start_out), 1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bf.busy_out && n < 2 * PERIOD + 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(bf.busy_out), 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bf.enable_in      = 1'b0;
        bf.sin_theta      = '0;
        bf.sign_bit       = 1'b0;
        bf.angle_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_tx", int'(bf.tx_out), 0);
        check("reset_busy", int'(bf.busy_out), 0);
        check("reset_start", int'(bf.burst_start_out), 0);
        check("reset_active", int'(bf.burst_active_out), 0);
        repeat (20) @(negedge clk);
        check("idle_without_enable", int'(bf.busy_out), 0);

        // Broadside, then angle updates issued mid-FIRE that land one ping later
        set_angle(0, 1'b0);
        push_ping(0, 0, 0);
        bf.enable_in = 1'b1;
        wait_start();
        repeat (100) @(negedge clk);
        set_angle(65536, 1'b0);
        push_ping(0, 2623, PERIOD + 1);
        wait_start();
        repeat (100) @(negedge clk);
        set_angle(65536, 1'b1);
        push_ping(2623, 0, PERIOD + 1);
        wait_start();
        repeat (100) @(negedge clk);
        set_angle(32768, 1'b0);
        push_ping(0, 1311, PERIOD + 1);

        // Drop enable mid-burst: ping completes, LISTEN runs out, then IDLE
        wait_start();
        repeat (2000) @(negedge clk);
        bf.enable_in = 1'b0;
        busy_q.push_back(PERIOD);
        wait_idle();
        repeat (30) @(negedge clk);
        check("idle_hold", int'(bf.busy_out), 0);

        // Async reset in the middle of a burst
        bf.enable_in = 1'b1;
        wait_start();
        repeat (100) @(negedge clk);
        check("tx_before_reset", int'(bf.tx_out), 1);
        #3 rst = 1'b1;
        bf.enable_in = 1'b0;
        #1;
        check("async_rst_tx", int'(bf.tx_out), 0);
        check("async_rst_busy", int'(bf.busy_out), 0);
        check("async_rst_active", int'(bf.burst_active_out), 0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        repeat (50) @(negedge clk);
        check("post_reset_busy", int'(bf.busy_out), 0);
        check("post_reset_tx", int'(bf.tx_out), 0);

        // Shadow angle was cleared by reset: broadside again
        push_ping(0, 0, 0);
        bf.enable_in = 1'b1;
        wait_start();
        repeat (100) @(negedge clk);
        bf.enable_in = 1'b0;
        busy_q.push_back(PERIOD);
        wait_idle();
        repeat (5) @(negedge clk);

        check("pending_pings", exp_q.size(), 0);
        check("pending_busy", busy_q.size(), 0);
`ifdef TX_BLANKING_EN
        check("pending_blank", blank_q.size(), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
